ntt_bram_reader: RTL and testbench

NTT_BRAM_READER -- requirements
Module: ntt_bram_reader

---
 rtl/ntt_pkg.sv | 32 +++
 rtl/ntt_bram_reader_if.sv | 34 +++
 rtl/ntt_fifo2.sv | 58 +++++
 rtl/ntt_bram_reader.sv | 137 +++++++++++++
 tb/tb_ntt_bram_reader.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg -- constants and types shared by the NTT BRAM blocks.
//   NTT_DEPTH_WORDS : number of 64-bit words in the coefficient BRAM
//   WORD_W          : coefficient word width
//   ADDR_W          : BRAM byte-address width
//   ADDR_SHIFT      : byte-address shift of a word index (8 bytes per word)
//   IDX_W           : width of a word index
//   state_t         : reader FSM states
//   beat_t          : one buffered output word plus its end-of-transfer tag
package ntt_pkg;

    localparam int NTT_DEPTH_WORDS = 512;
    localparam int WORD_W          = 64;
    localparam int ADDR_W          = 12;
    localparam int ADDR_SHIFT      = 3;
    localparam int IDX_W           = ADDR_W - ADDR_SHIFT;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } beat_t;

    function automatic logic [ADDR_W-1:0] word_to_addr(input logic [IDX_W-1:0] idx);
        return {idx, {ADDR_SHIFT{1'b0}}};
    endfunction

endpackage

// File: rtl/ntt_bram_reader_if.sv
// ntt_bram_reader_if -- BRAM read port and output stream of the reader.
//   BRAM_* : native BRAM port (reader drives address/enable, BRAM returns dout)
//   m_*    : valid/ready coefficient stream with end-of-transfer marker
//   master : the reader side; slave : BRAM plus stream consumer
interface ntt_bram_reader_if;
    import ntt_pkg::*;

    logic [ADDR_W-1:0] BRAM_addr;
    logic              BRAM_clk;
    logic [WORD_W-1:0] BRAM_din;
    logic [WORD_W-1:0] BRAM_dout;
    logic              BRAM_en;
    logic              BRAM_rst;
    logic              BRAM_we;
    logic [WORD_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (
        output BRAM_addr, BRAM_clk, BRAM_din, BRAM_en, BRAM_rst, BRAM_we,
        input  BRAM_dout,
        output m_data, m_valid, m_last,
        input  m_ready
    );

    modport slave (
        input  BRAM_addr, BRAM_clk, BRAM_din, BRAM_en, BRAM_rst, BRAM_we,
        output BRAM_dout,
        input  m_data, m_valid, m_last,
        output m_ready
    );

endinterface

// File: rtl/ntt_fifo2.sv
// ntt_fifo2 -- two-entry FIFO.
//   clk, rst : clock, synchronous active-high reset
//   push/din : write one entry (accepted when not full, or full while popping)
//   pop/dout : dout shows the head; pop removes it when not empty
//   full, empty, count : occupancy (0..2)
module ntt_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage is reset too so the head reads as zero after reset.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ntt_bram_reader.sv
// ntt_bram_reader -- streams len consecutive 64-bit words out of a BRAM,
// starting at word base and wrapping at the end of the memory.
//   clk, rst          : clock, synchronous active-high reset
//   start, base, len  : transfer request (sampled in IDLE only)
//   busy, done        : transfer in progress, one-cycle end-of-transfer pulse
//   bus (master)      : BRAM read port and m_data/m_valid/m_ready/m_last stream
module ntt_bram_reader
    import ntt_pkg::*;
#(
    parameter int DEPTH_WORDS = NTT_DEPTH_WORDS,
    parameter int LEN_W       = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IDX_W-1:0]   base,
    input  logic [LEN_W-1:0]   len,
    output logic               busy,
    output logic               done,
    ntt_bram_reader_if.master  bus
);

    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH_WORDS - 1);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   issued_q;
    logic [IDX_W-1:0]   idx_q;
    logic               inflight_q;
    logic               inflight_last_q;
    logic               done_q, done_d;

    logic [LEN_W-1:0]   len_clamped;
    logic               accept, zero_start;
    logic               issue, issue_last, pop;
    logic [2:0]         occupancy;
    logic [1:0]         fifo_count;
    logic               fifo_full, fifo_empty;
    logic [$bits(beat_t)-1:0] head_bits;
    beat_t              head, push_beat;

    assign len_clamped = (len > DEPTH_LEN) ? DEPTH_LEN : len;
    assign accept      = (state_q == IDLE) && start && (len != '0);
    assign zero_start  = (state_q == IDLE) && start && (len == '0);
    assign pop         = !fifo_empty && bus.m_ready;

    // Words buffered plus the read still in the BRAM pipeline may never
    // exceed the two FIFO slots, counting the slot freed by this cycle's pop.
    assign occupancy   = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign issue       = (state_q == RUN) && (occupancy < (3'd2 + {2'b00, pop}));
    assign issue_last  = issue && (issued_q == len_q - LEN_W'(1));

    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept)     state_d = RUN;
                if (zero_start) done_d  = 1'b1;
            end
            RUN: begin
                if (issue_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && head.last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            len_q           <= '0;
            issued_q        <= '0;
            idx_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q         <= state_d;
            done_q          <= done_d;
            // One-cycle BRAM latency: a read issued now returns next cycle.
            inflight_q      <= issue;
            inflight_last_q <= issue_last;
            if (accept) begin
                len_q    <= len_clamped;
                issued_q <= '0;
                idx_q    <= base;
            end else if (issue) begin
                issued_q <= issued_q + LEN_W'(1);
                idx_q    <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

    // Returning data is captured only for reads tracked as in flight, so
    // anything arriving after a reset is dropped.
    assign push_beat = '{last: inflight_last_q, data: bus.BRAM_dout};

    ntt_fifo2 #(
        .WIDTH($bits(beat_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .din   (push_beat),
        .pop   (pop),
        .dout  (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head = beat_t'(head_bits);

    assign bus.m_data    = head.data;
    assign bus.m_valid   = !fifo_empty;
    assign bus.m_last    = head.last && !fifo_empty;

    assign bus.BRAM_addr = word_to_addr(idx_q);
    assign bus.BRAM_en   = issue;
    assign bus.BRAM_we   = 1'b0;
    assign bus.BRAM_din  = '0;
    assign bus.BRAM_clk  = clk;
    assign bus.BRAM_rst  = rst;

    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_ntt_bram_reader.sv
// tb_ntt_bram_reader -- directed, table-driven bench for ntt_bram_reader.
// A behavioural BRAM returns data_of(word) one cycle after each enabled read;
// a negedge monitor records addresses, handshaken words and done pulses.
module tb_ntt_bram_reader;
    import ntt_pkg::*;

    localparam int LEN_W = 10;
    localparam int DEPTH = 512;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [8:0]       base = '0;
    logic [LEN_W-1:0] len = '0;
    logic             busy, done;
    logic             rand_ready = 1'b0;

    ntt_bram_reader_if bus();

    ntt_bram_reader #(
        .DEPTH_WORDS(DEPTH),
        .LEN_W      (LEN_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .base (base),
        .len  (len),
        .busy (busy),
        .done (done),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] data_of(input int idx);
        logic [31:0] lo;
        lo = 32'(idx) * 32'h9E37_79B1;
        return {16'hDA7A, 16'(idx), lo};
    endfunction

    // Behavioural BRAM with a one-cycle read latency.
    always @(posedge clk) begin
        if (bus.BRAM_en) bus.BRAM_dout <= data_of(int'(bus.BRAM_addr[11:3]));
    end

    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int          total = 0;
    int          bad = 0;
    int          start_cyc;
    int          en_cnt, hs_cnt, valid_cnt, done_cnt;
    int          first_valid_cyc, done_cyc, stall_err, max_occ;
    logic [63:0] got_data[$];
    logic        got_last[$];
    logic [11:0] addr_q[$];
    logic        prev_stall;
    logic [63:0] prev_data;
    logic        prev_last;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.BRAM_en) begin
                    en_cnt++;
                    addr_q.push_back(bus.BRAM_addr);
                end
                if (bus.m_valid) begin
                    valid_cnt++;
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    if (done_cyc < 0) done_cyc = cyc;
                end
                if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data ||
                                   bus.m_last !== prev_last)) stall_err++;
                prev_stall = bus.m_valid && !bus.m_ready;
                prev_data  = bus.m_data;
                prev_last  = bus.m_last;
                if (bus.m_valid && bus.m_ready) begin
                    hs_cnt++;
                    got_data.push_back(bus.m_data);
                    got_last.push_back(bus.m_last);
                end
                if (en_cnt - hs_cnt > max_occ) max_occ = en_cnt - hs_cnt;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear();
        en_cnt = 0; hs_cnt = 0; valid_cnt = 0; done_cnt = 0;
        first_valid_cyc = -1; done_cyc = -1; stall_err = 0; max_occ = 0;
        prev_stall = 1'b0;
        got_data.delete(); got_last.delete(); addr_q.delete();
    endtask

    task automatic pulse_start(input logic [8:0] b, input logic [LEN_W-1:0] l);
        @(posedge clk);
        #1;
        base = b; len = l; start = 1'b1; start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt > 0) break;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_xfer(input logic [8:0] b, input logic [LEN_W-1:0] l, input int budget);
        clear();
        pulse_start(b, l);
        wait_done(budget);
    endtask

    // Compares the recorded stream against n words starting at word b.
    task automatic verify_stream(input string tag, input int b, input int n);
        int derr = 0, aerr = 0, lerr = 0;
        check({tag, " words"}, 64'(got_data.size()), 64'(n));
        check({tag, " reads"}, 64'(en_cnt), 64'(n));
        for (int i = 0; i < got_data.size() && i < n; i++) begin
            if (got_data[i] !== data_of((b + i) % DEPTH)) derr++;
            if (got_last[i] !== (i == n - 1)) lerr++;
        end
        for (int i = 0; i < addr_q.size() && i < n; i++) begin
            if (addr_q[i] !== 12'(((b + i) % DEPTH) * 8)) aerr++;
        end
        check({tag, " data_err"}, 64'(derr), 64'd0);
        check({tag, " last_err"}, 64'(lerr), 64'd0);
        check({tag, " addr_err"}, 64'(aerr), 64'd0);
        check({tag, " done_cnt"}, 64'(done_cnt), 64'd1);
        check({tag, " busy_end"}, 64'(busy), 64'd0);
        check({tag, " occ_over"}, 64'(max_occ > 2), 64'd0);
    endtask

    typedef struct {
        logic [8:0]       base;
        logic [LEN_W-1:0] len;
        int               exp_cnt;
        int               exp_first;
        int               exp_last;
        int               exp_fv;
        int               exp_done;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [63:0] first_w, last_w;
        vecs[0] = '{base: 9'd0,   len: 10'd8,   exp_cnt: 8,   exp_first: 0,   exp_last: 7,   exp_fv: 3, exp_done: 11};
        vecs[1] = '{base: 9'd508, len: 10'd6,   exp_cnt: 6,   exp_first: 508, exp_last: 1,   exp_fv: 3, exp_done: 9};
        vecs[2] = '{base: 9'd100, len: 10'd1,   exp_cnt: 1,   exp_first: 100, exp_last: 100, exp_fv: 3, exp_done: 4};
        vecs[3] = '{base: 9'd511, len: 10'd2,   exp_cnt: 2,   exp_first: 511, exp_last: 0,   exp_fv: 3, exp_done: 5};
        vecs[4] = '{base: 9'd20,  len: 10'd600, exp_cnt: 512, exp_first: 20,  exp_last: 19,  exp_fv: 3, exp_done: 515};

        clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy",    64'(busy),        64'd0);
        check("rst done",    64'(done),        64'd0);
        check("rst m_valid", 64'(bus.m_valid), 64'd0);
        check("rst m_last",  64'(bus.m_last),  64'd0);
        check("rst m_data",  bus.m_data,       64'd0);
        check("rst en",      64'(bus.BRAM_en), 64'd0);
        check("rst we",      64'(bus.BRAM_we), 64'd0);
        check("rst din",     bus.BRAM_din,     64'd0);
        check("rst bram_rst", 64'(bus.BRAM_rst), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Table of full-speed transfers.
        for (int v = 0; v < 5; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            run_xfer(vecs[v].base, vecs[v].len, 700);
            verify_stream(tag, int'(vecs[v].base), vecs[v].exp_cnt);
            first_w = (got_data.size() > 0) ? got_data[0] : 64'd0;
            last_w  = (got_data.size() > 0) ? got_data[got_data.size() - 1] : 64'd0;
            check({tag, " first_word"}, first_w, data_of(vecs[v].exp_first));
            check({tag, " last_word"},  last_w,  data_of(vecs[v].exp_last));
            check({tag, " first_valid_lat"}, 64'(first_valid_cyc - start_cyc), 64'(vecs[v].exp_fv));
            check({tag, " done_lat"}, 64'(done_cyc - start_cyc), 64'(vecs[v].exp_done));
        end

        // Zero-length request: done only, no reads, no data.
        run_xfer(9'd10, 10'd0, 20);
        check("len0 done_lat", 64'(done_cyc - start_cyc), 64'd1);
        check("len0 done_cnt", 64'(done_cnt), 64'd1);
        check("len0 reads",    64'(en_cnt),   64'd0);
        check("len0 valid",    64'(valid_cnt), 64'd0);

        // Random backpressure.
        rand_ready = 1'b1;
        run_xfer(9'd300, 10'd16, 400);
        rand_ready = 1'b0;
        verify_stream("stall", 300, 16);
        check("stall stable_err", 64'(stall_err), 64'd0);

        // Reset in the middle of a 10-word transfer.
        clear();
        pulse_start(9'd0, 10'd10);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (hs_cnt >= 3) break;
        end
        check("abort reached3", 64'(hs_cnt >= 3), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort busy",    64'(busy),        64'd0);
        check("abort done",    64'(done),        64'd0);
        check("abort m_valid", 64'(bus.m_valid), 64'd0);
        check("abort m_last",  64'(bus.m_last),  64'd0);
        check("abort m_data",  bus.m_data,       64'd0);
        check("abort en",      64'(bus.BRAM_en), 64'd0);
        repeat (5) @(negedge clk);
        check("abort no_done", 64'(done_cnt), 64'd0);
        check("abort no_valid_after", 64'(bus.m_valid), 64'd0);
        run_xfer(9'd4, 10'd2, 30);
        verify_stream("after_abort", 4, 2);

        // Start pulses while busy are ignored.
        clear();
        pulse_start(9'd200, 10'd10);
        repeat (3) @(posedge clk);
        #1;
        base = 9'd0; len = 10'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(60);
        repeat (5) @(negedge clk);
        verify_stream("repulse", 200, 10);
        check("repulse done_lat", 64'(done_cyc - start_cyc), 64'd13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
